// File: rtl/fact_pkg.sv
// Shared definitions for the factorial accelerator register map and its command sequencer.
package fact_pkg;

    localparam logic [1:0] FACT_ADDR_N      = 2'd0;
    localparam logic [1:0] FACT_ADDR_GO     = 2'd1;
    localparam logic [1:0] FACT_ADDR_STATUS = 2'd2;
    localparam logic [1:0] FACT_ADDR_RESULT = 2'd3;

    localparam int FACT_ST_DONE = 0;
    localparam int FACT_ST_ERR  = 1;

    localparam int FACT_SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_N   = 3'd1,
        ST_WR_GO  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_POLL   = 3'd4,
        ST_RD_RES = 3'd5,
        ST_RESP   = 3'd6
    } fact_seq_state_t;

    // Counter width able to hold both the settle count and the poll limit.
    function automatic int fact_cnt_w(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w > 2) ? w : 2;
    endfunction

endpackage

// File: rtl/fact_seq_timer.sv
// Cycle counter with clear, enable and a "last cycle" flag (cnt == limit-1).
module fact_seq_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign last = (cnt == limit - W'(1));

endmodule

// File: rtl/fact_seq.sv
// Valid/ready command sequencer driving the factorial accelerator register bus.
// Optional poll timeout enabled by defining FACT_SEQ_TIMEOUT_EN.
module fact_seq
    import fact_pkg::*;
#(
    parameter int N_W        = 4,
    parameter int POLL_LIMIT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [N_W-1:0] req_n,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [31:0]    rsp_result,
    output logic           rsp_err,
    output logic           rsp_timeout,
    output logic           busy,
    output logic [1:0]     fact_a,
    output logic           fact_we,
    output logic [3:0]     fact_wd,
    input  logic [31:0]    fact_rd
);

`ifdef FACT_SEQ_TIMEOUT_EN
    localparam int CNT_W = fact_cnt_w(POLL_LIMIT);
`else
    localparam int CNT_W = 2;
`endif

    fact_seq_state_t state;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_last;
    logic [CNT_W-1:0] tmr_limit;

    // One counter serves SETTLE and POLL; it is cleared on entry to each of them.
    assign tmr_en  = (state == ST_SETTLE) || (state == ST_POLL);
    assign tmr_clr = !tmr_en || ((state == ST_SETTLE) && tmr_last);

`ifdef FACT_SEQ_TIMEOUT_EN
    logic timeout_q;
    assign tmr_limit   = (state == ST_SETTLE) ? CNT_W'(FACT_SETTLE_CYCLES) : CNT_W'(POLL_LIMIT);
    assign rsp_timeout = timeout_q;
`else
    logic unused_poll_limit;
    assign unused_poll_limit = (POLL_LIMIT != 0);
    assign tmr_limit   = CNT_W'(FACT_SETTLE_CYCLES);
    assign rsp_timeout = 1'b0;
`endif

    fact_seq_timer #(.W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .last  (tmr_last)
    );

    // Bus and handshake outputs are loaded together with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            fact_a     <= FACT_ADDR_N;
            fact_we    <= 1'b0;
            fact_wd    <= '0;
`ifdef FACT_SEQ_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        state     <= ST_WR_N;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        fact_a    <= FACT_ADDR_N;
                        fact_we   <= 1'b1;
                        fact_wd   <= 4'(req_n);
                    end
                end
                ST_WR_N: begin
                    state   <= ST_WR_GO;
                    fact_a  <= FACT_ADDR_GO;
                    fact_wd <= 4'b0001;
                end
                ST_WR_GO: begin
                    state   <= ST_SETTLE;
                    fact_a  <= FACT_ADDR_STATUS;
                    fact_we <= 1'b0;
                    fact_wd <= '0;
                end
                ST_SETTLE: begin
                    if (tmr_last) begin
                        state <= ST_POLL;
                    end
                end
                ST_POLL: begin
                    // Error wins over done; a flagged job never reads the result.
                    if (fact_rd[FACT_ST_ERR]) begin
                        state      <= ST_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        fact_a     <= FACT_ADDR_N;
`ifdef FACT_SEQ_TIMEOUT_EN
                        timeout_q  <= 1'b0;
`endif
                    end else if (fact_rd[FACT_ST_DONE]) begin
                        state  <= ST_RD_RES;
                        fact_a <= FACT_ADDR_RESULT;
                    end
`ifdef FACT_SEQ_TIMEOUT_EN
                    else if (tmr_last) begin
                        state      <= ST_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        timeout_q  <= 1'b1;
                        fact_a     <= FACT_ADDR_N;
                    end
`endif
                end
                ST_RD_RES: begin
                    state      <= ST_RESP;
                    rsp_valid  <= 1'b1;
                    rsp_result <= fact_rd;
                    rsp_err    <= 1'b0;
                    fact_a     <= FACT_ADDR_N;
`ifdef FACT_SEQ_TIMEOUT_EN
                    timeout_q  <= 1'b0;
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                    fact_a    <= FACT_ADDR_N;
                    fact_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fact_seq.sv
// Bench for fact_seq: behavioural accelerator on the register bus, scoreboard on the response channel.
module tb_fact_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_n;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic [1:0]  fact_a;
    logic        fact_we;
    logic [3:0]  fact_wd;
    logic [31:0] fact_rd;

    fact_seq #(.N_W(4), .POLL_LIMIT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_n       (req_n),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .fact_a      (fact_a),
        .fact_we     (fact_we),
        .fact_wd     (fact_wd),
        .fact_rd     (fact_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Accelerator model: go clears the flags, result/done (or err) appear acc_lat cycles later.
    logic [3:0]  acc_n;
    logic        acc_done;
    logic        acc_err;
    logic [31:0] acc_res;
    int          acc_cnt;
    int          acc_lat = 1;
    bit          stub_never = 1'b0;

    function automatic logic [31:0] fact_calc(input logic [3:0] n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
        return p;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            acc_n    <= '0;
            acc_done <= 1'b0;
            acc_err  <= 1'b0;
            acc_res  <= '0;
            acc_cnt  <= 0;
        end else begin
            if (fact_we && fact_a == 2'd0) acc_n <= fact_wd;
            if (fact_we && fact_a == 2'd1 && fact_wd[0]) begin
                acc_done <= 1'b0;
                acc_err  <= 1'b0;
                acc_cnt  <= stub_never ? 0 : acc_lat;
            end else if (acc_cnt == 1) begin
                acc_cnt  <= 0;
                acc_done <= 1'b1;
                if (acc_n > 4'd12) acc_err <= 1'b1;
                else acc_res <= fact_calc(acc_n);
            end else if (acc_cnt > 1) begin
                acc_cnt <= acc_cnt - 1;
            end
        end
    end

    always_comb begin
        fact_rd = '0;
        case (fact_a)
            2'd0: fact_rd = {28'd0, acc_n};
            2'd2: fact_rd = {30'd0, acc_err, acc_done};
            2'd3: fact_rd = acc_res;
            default: fact_rd = '0;
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic        err;
        logic        to;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    // Scoreboard monitor: pops on every accepted response.
    always @(negedge clk) begin
        if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rsp", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("rsp_result", rsp_result, e.res);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
            end
        end
    end

    // Bus observer.
    int         we_cnt = 0;
    int         a2_cnt = 0;
    int         wrn_cyc = -1;
    int         wrgo_cyc = -1;
    int         rv_cyc = -1;
    logic [3:0] wrn_wd = '0;
    logic [3:0] wrgo_wd = '0;
    bit         seen_a3 = 1'b0;
    logic       rv_d = 1'b0;

    always @(negedge clk) begin
        if (fact_we === 1'b1) we_cnt++;
        if (fact_we === 1'b1 && fact_a == 2'd0) begin wrn_cyc = cyc; wrn_wd = fact_wd; end
        if (fact_we === 1'b1 && fact_a == 2'd1) begin wrgo_cyc = cyc; wrgo_wd = fact_wd; end
        if (fact_a === 2'd3) seen_a3 = 1'b1;
        if (fact_a === 2'd2) a2_cnt++;
        if (rsp_valid === 1'b1 && rv_d !== 1'b1) rv_cyc = cyc;
        rv_d = rsp_valid;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [3:0] n, input bit push, input logic [31:0] er,
                         input bit ee, input bit et, output int acc);
        exp_t x;
        tick();
        req_valid = 1'b1;
        req_n     = n;
        for (int k = 0; k < 200 && req_ready !== 1'b1; k++) tick();
        check("req_accept", 32'(req_ready), 32'd1);
        acc = cyc;
        if (push) begin
            x.res = er; x.err = ee; x.to = et;
            sb.push_back(x);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 300 && busy !== 1'b0; k++) tick();
        if (k >= 300) check(name, 32'(busy), 32'd0);
    endtask

    int acc;
    int base;

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_n     = '0;
        rsp_ready = 1'b1;

        // Reset held three cycles.
        repeat (3) tick();
        check("rst_flags", {26'd0, req_ready, rsp_valid, busy, fact_we, rsp_err, rsp_timeout}, 32'b100000);
        check("rst_fact_a", 32'(fact_a), 32'd0);
        check("rst_fact_wd", 32'(fact_wd), 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_no_we", 32'(we_cnt), 32'd0);
        rst = 1'b1;

        // n=5 with the fastest accelerator: exact bus timing and 7-cycle latency.
        acc_lat = 1;
        issue(4'd5, 1'b1, 32'd120, 1'b0, 1'b0, acc);
        wait_idle("idle_n5");
        check("wr_n_cycle", 32'(wrn_cyc - acc), 32'd1);
        check("wr_n_data", 32'(wrn_wd), 32'd5);
        check("wr_go_cycle", 32'(wrgo_cyc - acc), 32'd2);
        check("wr_go_data", 32'(wrgo_wd), 32'd1);
        check("latency_min", 32'(rv_cyc - acc), 32'd7);

        acc_lat = 2;
        issue(4'd12, 1'b1, 32'd479001600, 1'b0, 1'b0, acc);
        wait_idle("idle_n12");
        issue(4'd0, 1'b1, 32'd1, 1'b0, 1'b0, acc);
        wait_idle("idle_n0");

        // n=13 flags err (with done also set): no result read, response one cycle after POLL.
        seen_a3 = 1'b0;
        acc_lat = 3;
        issue(4'd13, 1'b1, 32'd0, 1'b1, 1'b0, acc);
        wait_idle("idle_n13");
        check("err_no_result_read", 32'(seen_a3), 32'd0);
        check("err_latency", 32'(rv_cyc - acc), 32'd7);

        // Backpressure: response held 10 cycles while a new request waits.
        rsp_ready = 1'b0;
        acc_lat   = 2;
        issue(4'd4, 1'b1, 32'd24, 1'b0, 1'b0, acc);
        for (int k = 0; k < 100 && rsp_valid !== 1'b1; k++) tick();
        req_valid = 1'b1;
        req_n     = 4'd2;
        base      = we_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_result", rsp_result, 32'd24);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        check("hold_no_we", 32'(we_cnt - base), 32'd0);
        rsp_ready = 1'b1;
        tick();
        check("post_rsp_idle", {30'd0, req_ready, rsp_valid}, 32'b10);
        e.res = 32'd2; e.err = 1'b0; e.to = 1'b0;
        sb.push_back(e);
        acc = cyc;
        tick();
        req_valid = 1'b0;
        wait_idle("idle_n2");
        check("queued_req_wr_n", 32'(wrn_cyc - acc), 32'd1);

        // Reset in the middle of POLL.
        acc_lat = 30;
        issue(4'd7, 1'b0, 32'd0, 1'b0, 1'b0, acc);
        while (cyc < acc + 8) tick();
        check("in_poll_addr", 32'(fact_a), 32'd2);
        rst = 1'b0;
        tick();
        check("midrst_flags", {28'd0, req_ready, busy, fact_we, rsp_valid}, 32'b1000);
        check("midrst_addr", 32'(fact_a), 32'd0);
        rst  = 1'b1;
        base = we_cnt;
        repeat (5) tick();
        check("midrst_no_we", 32'(we_cnt - base), 32'd0);
        acc_lat = 2;
        issue(4'd3, 1'b1, 32'd6, 1'b0, 1'b0, acc);
        wait_idle("idle_n3");

`ifdef FACT_SEQ_TIMEOUT_EN
        // Accelerator never completes: timeout after 8 POLL cycles (plus 2 SETTLE on status address).
        stub_never = 1'b1;
        base       = a2_cnt;
        issue(4'd6, 1'b1, 32'd0, 1'b1, 1'b1, acc);
        wait_idle("idle_timeout");
        check("timeout_status_cycles", 32'(a2_cnt - base), 32'd10);
        check("timeout_latency", 32'(rv_cyc - acc), 32'd13);
        stub_never = 1'b0;
`endif

        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
